// File: rtl/counter_read_control.sv
// Read-side sequencer for one 8254 counter: decodes latch/mode/read-back
// control words, holds the count and status latches and steps the byte pointer.
module counter_read_control #(
  parameter int COUNTER_ID = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        control_word_wr,
  input  logic [7:0]  control_word,
  input  logic        read,
  input  logic [15:0] current_count,
  input  logic [7:0]  status_in,
  output logic [7:0]  databus,
  output logic        latched,
  output logic        status_latched
);

  localparam logic [1:0] SC_ID   = 2'(COUNTER_ID);
  localparam int         SEL_BIT = COUNTER_ID + 1;

  typedef enum logic {PTR_LSB, PTR_MSB} byte_ptr_t;

  logic [7:0]  databus_reg, databus_next;
  logic        latched_reg, latched_next;
  logic        status_latched_reg, status_latched_next;
  logic [15:0] ol_reg, ol_next;
  logic [7:0]  sl_reg, sl_next;
  logic [1:0]  rw_mode_reg, rw_mode_next;
  byte_ptr_t   byte_ptr_reg, byte_ptr_next;
  logic [15:0] src;

  logic [1:0] cw_sc;
  logic [1:0] cw_rw;
  logic       unused_cw_bits;

  assign cw_sc          = control_word[7:6];
  assign cw_rw          = control_word[5:4];
  assign unused_cw_bits = ^control_word[3:0];

  always_comb begin
    databus_next        = databus_reg;
    latched_next        = latched_reg;
    status_latched_next = status_latched_reg;
    ol_next             = ol_reg;
    sl_next             = sl_reg;
    rw_mode_next        = rw_mode_reg;
    byte_ptr_next       = byte_ptr_reg;
    src                 = latched_reg ? ol_reg : current_count;

    // The read is served from pre-edge state; control-word effects below
    // are layered on top of it so they win on a simultaneous edge.
    if (read) begin
      if (status_latched_reg) begin
        databus_next        = sl_reg;
        status_latched_next = 1'b0;
      end else begin
        case (rw_mode_reg)
          2'b01: begin
            databus_next = src[7:0];
            latched_next = 1'b0;
          end
          2'b10: begin
            databus_next = src[15:8];
            latched_next = 1'b0;
          end
          default: begin
            if (byte_ptr_reg == PTR_LSB) begin
              databus_next  = src[7:0];
              byte_ptr_next = PTR_MSB;
            end else begin
              databus_next  = src[15:8];
              byte_ptr_next = PTR_LSB;
              latched_next  = 1'b0;
            end
          end
        endcase
      end
    end

    if (control_word_wr) begin
      if (cw_sc == SC_ID) begin
        if (cw_rw == 2'b00) begin
          if (!latched_next) begin
            ol_next      = current_count;
            latched_next = 1'b1;
          end
        end else begin
          rw_mode_next        = cw_rw;
          latched_next        = 1'b0;
          status_latched_next = 1'b0;
          byte_ptr_next       = PTR_LSB;
        end
      end else if (cw_sc == 2'b11 && control_word[SEL_BIT]) begin
        // Read-back: bit 5 low requests the count, bit 4 low the status.
        if (!control_word[5] && !latched_next) begin
          ol_next      = current_count;
          latched_next = 1'b1;
        end
        if (!control_word[4] && !status_latched_next) begin
          sl_next             = status_in;
          status_latched_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      databus_reg        <= 8'h00;
      latched_reg        <= 1'b0;
      status_latched_reg <= 1'b0;
      ol_reg             <= 16'h0000;
      sl_reg             <= 8'h00;
      rw_mode_reg        <= 2'b11;
      byte_ptr_reg       <= PTR_LSB;
    end else begin
      databus_reg        <= databus_next;
      latched_reg        <= latched_next;
      status_latched_reg <= status_latched_next;
      ol_reg             <= ol_next;
      sl_reg             <= sl_next;
      rw_mode_reg        <= rw_mode_next;
      byte_ptr_reg       <= byte_ptr_next;
    end
  end

  assign databus        = databus_reg;
  assign latched        = latched_reg;
  assign status_latched = status_latched_reg;

endmodule

// File: tb/tb_counter_read_control.sv
// Bench for counter_read_control: counter 0 and counter 1 instances share the
// bus and are checked against an event-level model of the 8254 read rules.
module tb_counter_read_control;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        control_word_wr = 1'b0;
  logic [7:0]  control_word = 8'h00;
  logic        read = 1'b0;
  logic [15:0] current_count = 16'h0000;
  logic [7:0]  status_in = 8'h00;
  logic [7:0]  databus0, databus1;
  logic        latched0, latched1, slat0, slat1;

  int checks = 0;
  int fails  = 0;
  bit verbose = 1'b1;

  // Model state per counter index
  logic [7:0]  m_db   [2];
  bit          m_lat  [2];
  bit          m_slat [2];
  logic [15:0] m_ol   [2];
  logic [7:0]  m_sl   [2];
  logic [1:0]  m_mode [2];
  bit          m_msb  [2];

  always #5 clk = ~clk;

  counter_read_control #(.COUNTER_ID(0)) dut0 (
    .clk(clk), .reset(reset), .control_word_wr(control_word_wr),
    .control_word(control_word), .read(read), .current_count(current_count),
    .status_in(status_in), .databus(databus0), .latched(latched0),
    .status_latched(slat0)
  );

  counter_read_control #(.COUNTER_ID(1)) dut1 (
    .clk(clk), .reset(reset), .control_word_wr(control_word_wr),
    .control_word(control_word), .read(read), .current_count(current_count),
    .status_in(status_in), .databus(databus1), .latched(latched1),
    .status_latched(slat1)
  );

  // Applies one bus event to counter i: the read consumes the old state,
  // then the control word is applied to whatever the read left behind.
  task automatic model_step(input int i);
    logic [15:0] v;
    if (reset) begin
      m_db[i] = 8'h00; m_lat[i] = 0; m_slat[i] = 0; m_ol[i] = 16'h0;
      m_sl[i] = 8'h00; m_mode[i] = 2'b11; m_msb[i] = 0;
    end else begin
      if (read) begin
        v = m_lat[i] ? m_ol[i] : current_count;
        if (m_slat[i]) begin
          m_db[i] = m_sl[i];
          m_slat[i] = 0;
        end else if (m_mode[i] == 2'b01) begin
          m_db[i] = v[7:0]; m_lat[i] = 0;
        end else if (m_mode[i] == 2'b10) begin
          m_db[i] = v[15:8]; m_lat[i] = 0;
        end else if (!m_msb[i]) begin
          m_db[i] = v[7:0]; m_msb[i] = 1;
        end else begin
          m_db[i] = v[15:8]; m_msb[i] = 0; m_lat[i] = 0;
        end
      end
      if (control_word_wr) begin
        if (int'(control_word[7:6]) == i) begin
          if (control_word[5:4] == 2'b00) begin
            if (!m_lat[i]) begin m_ol[i] = current_count; m_lat[i] = 1; end
          end else begin
            m_mode[i] = control_word[5:4];
            m_lat[i] = 0; m_slat[i] = 0; m_msb[i] = 0;
          end
        end else if (control_word[7:6] == 2'b11 && control_word[1 + i]) begin
          if (!control_word[5] && !m_lat[i]) begin m_ol[i] = current_count; m_lat[i] = 1; end
          if (!control_word[4] && !m_slat[i]) begin m_sl[i] = status_in; m_slat[i] = 1; end
        end
      end
    end
  endtask

  task automatic cycle(input bit wr, input logic [7:0] cw, input bit rd);
    control_word_wr = wr;
    control_word    = cw;
    read            = rd;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    if (verbose)
      $display("t=%0t rst=%0d wr=%0d cw=%h rd=%0d cnt=%h st=%h | c0 db=%h lat=%0d sl=%0d | c1 db=%h lat=%0d sl=%0d",
               $time, reset, wr, cw, rd, current_count, status_in,
               databus0, latched0, slat0, databus1, latched1, slat1);
    control_word_wr = 1'b0;
    read            = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // Reset asserted together with a latch command and a read must win.
    current_count = 16'hFFFF;
    reset = 1'b1;
    cycle(1'b1, 8'h00, 1'b1);
    reset = 1'b0;
    checks++; if (databus0 !== 8'h00) begin fails++; $display("FAIL reset_db: got %h want 00", databus0); end
    checks++; if ({latched0, slat0, latched1, slat1} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b want 0000", {latched0, slat0, latched1, slat1}); end
  endtask

  task automatic test_mode11_live();
    current_count = 16'h1234;
    cycle(1'b1, 8'h30, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'h34 || latched0 !== 1'b0) begin fails++; $display("FAIL live_lsb: got %h/%0d want 34/0", databus0, latched0); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'h12 || latched0 !== 1'b0) begin fails++; $display("FAIL live_msb: got %h/%0d want 12/0", databus0, latched0); end
  endtask

  task automatic test_latch();
    current_count = 16'hABCD;
    cycle(1'b1, 8'h00, 1'b0);
    checks++; if (latched0 !== 1'b1) begin fails++; $display("FAIL latch_set: got %0d want 1", latched0); end
    current_count = 16'h0001;
    cycle(1'b0, 8'h00, 1'b0);
    current_count = 16'h0002;
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'hCD || latched0 !== 1'b1) begin fails++; $display("FAIL latch_lsb: got %h/%0d want cd/1", databus0, latched0); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'hAB || latched0 !== 1'b0) begin fails++; $display("FAIL latch_msb: got %h/%0d want ab/0", databus0, latched0); end
  endtask

  task automatic test_readback();
    status_in = 8'hB6;
    current_count = 16'h5678;
    cycle(1'b1, 8'hC2, 1'b0);
    checks++; if ({latched0, slat0} !== 2'b11) begin fails++; $display("FAIL rb_set: got %b want 11", {latched0, slat0}); end
    checks++; if ({latched1, slat1} !== 2'b00) begin fails++; $display("FAIL rb_other_ctr: got %b want 00", {latched1, slat1}); end
    current_count = 16'h0F0F;
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'hB6 || {latched0, slat0} !== 2'b10) begin fails++; $display("FAIL rb_status: got %h/%b want b6/10", databus0, {latched0, slat0}); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'h78 || latched0 !== 1'b1) begin fails++; $display("FAIL rb_lsb: got %h/%0d want 78/1", databus0, latched0); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'h56 || latched0 !== 1'b0) begin fails++; $display("FAIL rb_msb: got %h/%0d want 56/0", databus0, latched0); end
  endtask

  task automatic test_mode10();
    cycle(1'b1, 8'h20, 1'b0);
    current_count = 16'h9A00;
    cycle(1'b1, 8'h00, 1'b0);
    current_count = 16'h1111;
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'h9A || latched0 !== 1'b0) begin fails++; $display("FAIL m10_latched: got %h/%0d want 9a/0", databus0, latched0); end
    current_count = 16'h4455;
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'h44) begin fails++; $display("FAIL m10_live1: got %h want 44", databus0); end
    current_count = 16'h7700;
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'h77) begin fails++; $display("FAIL m10_live2: got %h want 77", databus0); end
  endtask

  task automatic test_abort_reset();
    cycle(1'b1, 8'h30, 1'b0);
    current_count = 16'h1111;
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h30, 1'b0);
    current_count = 16'h2233;
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'h33) begin fails++; $display("FAIL abort_lsb: got %h want 33", databus0); end
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    do_reset();
    checks++; if (databus0 !== 8'h00 || {latched0, slat0} !== 2'b00) begin fails++; $display("FAIL midseq_reset: got %h/%b want 00/00", databus0, {latched0, slat0}); end
    current_count = 16'hBEEF;
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'hEF) begin fails++; $display("FAIL reset_ptr_lsb: got %h want ef", databus0); end
  endtask

  task automatic test_counter1();
    do_reset();
    current_count = 16'h3C5A;
    status_in = 8'h11;
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0);
    checks++; if ({latched1, slat1} !== 2'b00) begin fails++; $display("FAIL id1_ignore: got %b want 00", {latched1, slat1}); end
    cycle(1'b1, 8'hC4, 1'b0);
    checks++; if ({latched1, slat1} !== 2'b11) begin fails++; $display("FAIL id1_rb: got %b want 11", {latched1, slat1}); end
    current_count = 16'h0000;
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus1 !== 8'h11) begin fails++; $display("FAIL id1_status: got %h want 11", databus1); end
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus1 !== 8'h3C || latched1 !== 1'b0) begin fails++; $display("FAIL id1_msb: got %h/%0d want 3c/0", databus1, latched1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    current_count = 16'h1000;
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    current_count = 16'h2345;
    // MSB read releases the old latch on the same edge a new latch is taken.
    cycle(1'b1, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'h10 || latched0 !== 1'b1) begin fails++; $display("FAIL b2b_relatch: got %h/%0d want 10/1", databus0, latched0); end
    current_count = 16'h0000;
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'h45) begin fails++; $display("FAIL b2b_lsb: got %h want 45", databus0); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (databus0 !== 8'h23 || latched0 !== 1'b0) begin fails++; $display("FAIL b2b_msb: got %h/%0d want 23/0", databus0, latched0); end
  endtask

  task automatic test_random();
    logic [7:0] od;
    bit ol, os;
    verbose = 1'b0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      current_count = 16'($urandom);
      status_in     = 8'($urandom);
      reset         = ($urandom_range(0, 99) == 0);
      cycle(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 1) == 1));
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
        od = (i == 0) ? databus0 : databus1;
        ol = (i == 0) ? latched0 : latched1;
        os = (i == 0) ? slat0 : slat1;
        checks++;
        if (od !== m_db[i] || ol !== m_lat[i] || os !== m_slat[i]) begin
          fails++;
          $display("FAIL rand_c%0d_%0d: got db=%h lat=%0d sl=%0d want db=%h lat=%0d sl=%0d",
                   i, n, od, ol, os, m_db[i], m_lat[i], m_slat[i]);
        end
      end
    end
    verbose = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mode11_live();
    test_latch();
    test_readback();
    test_mode10();
    test_abort_reset();
    test_counter1();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
